brarb: RTL and testbench
========================

# brarb

Bus-request arbiter that shares one UNIBUS BR level between up to eight interrupting device blocks (pc11, kl11 and similar). Each device presents its level-type interrupt request and vector; brarb selects one winner, drives a single request/vector pair to the bus interface, and routes the returning grant to the winner only. The selection is locked from request to grant, so the vector on the bus never changes under an in-flight grant.

## Interface
Parameters:
- NDEV, 4, number of requesting devices, legal range 1..8

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- devreq  in  NDEV  per-device interrupt request level (device `intreq`)
- devvec  in  8*NDEV  per-device vector; device i occupies bits [8i+7:8i]
- devgnt  out  NDEV  one-cycle grant pulse to the winning device only
- devgvec  out  8  vector accompanying devgnt (copy of busgvec)
- busreq  out  1  request to the bus interface
- busvec  out  8  vector of the current winner
- busgnt  in  1  grant from the bus interface
- busgvec  in  8  vector being granted
- winner  out  3  index of the locked winner; valid while busreq=1
- grantcnt  out  16  total grants delivered, wraps 0xFFFF->0

## Operation
- States: IDLE, REQ, DONE. All outputs are registered.
- IDLE: if any devreq bit is 1, select a winner per the priority rule, latch its index and devvec slice, and go to REQ. busreq=1 and busvec=latched vector from the next cycle onward. If no devreq bit is set, stay in IDLE with busreq=0.
- REQ: busreq and busvec are held constant.
  - busgnt=1 and busgvec==busvec: pulse devgnt[winner]=1 for one cycle, devgvec=busgvec, busreq=0, grantcnt+1, go to DONE.
  - busgnt=1 with a mismatched vector: ignored; stay in REQ.
  - devreq[winner]=0 and no matching grant (software cleared IE or DONE): withdraw. busreq=0, go to IDLE; no devgnt, counter unchanged.
  - Matching grant in the same cycle devreq[winner] drops: the grant wins and is delivered.
- DONE: lasts exactly one cycle with busreq=0, which gives the device time to clear its request. Then go to IDLE.
- Changes on devvec, or on other devreq bits, during REQ have no effect.
- Fixed priority: the lowest set index wins.

## Timing
- Reset values: state=IDLE, busreq=0, busvec=0, devgnt=0, devgvec=0, winner=0, grantcnt=0, round-robin pointer=0.
- devreq rising at the edge ending cycle t: busreq=1 in cycle t+1.
- Matching busgnt sampled at edge g: devgnt pulse and busreq=0 in cycle g+1.
- The earliest next busreq is in cycle g+3 (DONE at g+1, IDLE at g+2).
- A withdrawal drops busreq one cycle after devreq[winner] falls.
- devgnt is never asserted for more than one cycle, and never to more than one device.
- RESET in any state forces the reset values on the next edge. A pending grant is discarded.
- NDEV=1 degenerates to a pass-through with the same latency. devreq bits at indices ≥NDEV do not exist.

## Configuration
- BRARB_RR_EN defined: round-robin priority.
  - A pointer holds the index after the last granted device, mod NDEV.
  - The search starts at the pointer and wraps.
  - The pointer advances only on a delivered grant; withdrawals leave it unchanged.
- BRARB_RR_EN undefined: fixed priority, lowest index wins. There is no pointer register.

## Test plan
- Reset, then devreq=0001, devvec[7:0]=0x38: busreq=1 and busvec=0x38 one cycle later. busgnt with busgvec=0x38 gives devgnt=0001 and devgvec=0x38 for one cycle, and grantcnt=1.
- devreq=0110 with vectors 0x40 (dev1) and 0x44 (dev2), each device dropping its request on grant:
  - without RR, dev1 is granted, then dev2;
  - with BRARB_RR_EN and pointer=2, dev2 is granted first.
- Winner dev0 (0x38) in REQ, busgnt with busgvec=0x70: no devgnt, busreq stays 1. The following busgvec=0x38 is delivered.
- Winner dev0 in REQ, devreq[0] falls with no grant: busreq=0 next cycle, grantcnt unchanged. dev1 still requesting gives busreq=1 with dev1's vector two cycles later.
- Matching busgnt in the same cycle devreq[winner] falls: devgnt is still pulsed and grantcnt increments.
- RESET asserted in REQ the cycle before a matching busgnt: no devgnt, busreq=0, grantcnt=0. Starting from grantcnt=0xFFFF, one grant wraps it to 0.

Source files
------------

// File: rtl/brarb_if.sv
// brarb_if: device-side and bus-side request/vector/grant signals of the BR arbiter.
// master: the arbiter's view. slave: the view of the devices and bus interface that face it.
interface brarb_if #(
    parameter int unsigned NDEV = 4
);
    logic [NDEV-1:0]   devreq;
    logic [8*NDEV-1:0] devvec;
    logic [NDEV-1:0]   devgnt;
    logic [7:0]        devgvec;
    logic              busreq;
    logic [7:0]        busvec;
    logic              busgnt;
    logic [7:0]        busgvec;

    modport master (
        input  devreq, devvec, busgnt, busgvec,
        output devgnt, devgvec, busreq, busvec
    );

    modport slave (
        output devreq, devvec, busgnt, busgvec,
        input  devgnt, devgvec, busreq, busvec
    );
endinterface

// File: rtl/brarb.sv
// brarb: shares one UNIBUS BR level between up to eight interrupting devices.
// The winner and its vector are locked from request to grant, and only the winner sees the grant.
// The default build uses fixed priority, where the lowest set index wins.
// Defining BRARB_RR_EN selects round-robin priority instead. A pointer register then holds the
// index after the last granted device and advances only when a grant is delivered.
module brarb #(
    parameter int unsigned NDEV = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    brarb_if.master     bus,
    output logic [2:0]  winner,
    output logic [15:0] grantcnt
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e          state_q;
    logic [2:0]      winner_q;
    logic [15:0]     grantcnt_q;

    logic            sel_found;
    logic [2:0]      sel_idx;
    logic [7:0]      sel_vec;
    logic [NDEV-1:0] win_onehot;
    logic            win_req;
    logic            grant_hit;

    assign winner   = winner_q;
    assign grantcnt = grantcnt_q;

`ifdef BRARB_RR_EN
    logic [2:0]         ptr_q;
    logic [2*NDEV-1:0]  req_rot;
    logic [16*NDEV-1:0] vec_rot;
    logic [3:0]         sel_sum;

    // Round-robin pick: rotate requests so the pointer sits at bit 0, take the first set bit.
    always_comb begin
        req_rot   = {bus.devreq, bus.devreq} >> ptr_q;
        vec_rot   = {bus.devvec, bus.devvec} >> {ptr_q, 3'b000};
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_vec   = '0;
        sel_sum   = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (!sel_found && req_rot[k]) begin
                sel_found = 1'b1;
                sel_sum   = {1'b0, ptr_q} + 4'(k);
                if (sel_sum >= 4'(NDEV)) begin
                    sel_sum = sel_sum - 4'(NDEV);
                end
                sel_idx   = sel_sum[2:0];
                sel_vec   = vec_rot[8*k +: 8];
            end
        end
    end
`else
    // Fixed-priority pick: the lowest set request index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_vec   = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (!sel_found && bus.devreq[k]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(k);
                sel_vec   = bus.devvec[8*k +: 8];
            end
        end
    end
`endif

    // One-hot of the locked winner, used for grant routing and withdrawal detection.
    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NDEV; i++) begin
            win_onehot[i] = (winner_q == 3'(i));
        end
    end

    assign win_req   = |(bus.devreq & win_onehot);
    assign grant_hit = bus.busgnt && (bus.busgvec == bus.busvec);

    // Arbiter FSM with all outputs registered; a matching grant beats a same-cycle withdrawal.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= StIdle;
            bus.busreq  <= 1'b0;
            bus.busvec  <= '0;
            bus.devgnt  <= '0;
            bus.devgvec <= '0;
            winner_q    <= '0;
            grantcnt_q  <= '0;
`ifdef BRARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            bus.devgnt <= '0;
            unique case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        winner_q   <= sel_idx;
                        bus.busvec <= sel_vec;
                        bus.busreq <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (grant_hit) begin
                        bus.devgnt  <= win_onehot;
                        bus.devgvec <= bus.busgvec;
                        bus.busreq  <= 1'b0;
                        grantcnt_q  <= grantcnt_q + 16'd1;
`ifdef BRARB_RR_EN
                        ptr_q       <= (winner_q == 3'(NDEV - 1)) ? 3'd0 : winner_q + 3'd1;
`endif
                        state_q     <= StDone;
                    end else if (!win_req) begin
                        bus.busreq <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brarb.sv
// tb_brarb: directed table of single-edge vectors, then hand-written priority and wrap sequences.
// Each check compares {busreq, busvec, devgnt, devgvec, winner, grantcnt} after one clock edge.
module tb_brarb;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [2:0]  winner;
    logic [15:0] grantcnt;

    int nvec = 0;
    int nerr = 0;

    brarb_if #(.NDEV(4)) bif ();

    brarb #(.NDEV(4)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .bus      (bif),
        .winner   (winner),
        .grantcnt (grantcnt)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  req;
        logic        gnt;
        logic [7:0]  gvec;
        logic        bq;
        logic [7:0]  bv;
        logic [3:0]  dg;
        logic [7:0]  dgv;
        logic [2:0]  w;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic rst, input logic [3:0] req,
                       input logic gnt, input logic [7:0] gvec, input logic bq,
                       input logic [7:0] bv, input logic [3:0] dg, input logic [7:0] dgv,
                       input logic [2:0] w, input logic [15:0] cnt);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.gnt = gnt; v.gvec = gvec;
        v.bq = bq; v.bv = bv; v.dg = dg; v.dgv = dgv; v.w = w; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string name, input logic bq, input logic [7:0] bv,
                       input logic [3:0] dg, input logic [7:0] dgv, input logic [2:0] w,
                       input logic [15:0] cnt);
        logic [39:0] act;
        logic [39:0] exp;
        act = {bif.busreq, bif.busvec, bif.devgnt, bif.devgvec, winner, grantcnt};
        exp = {bq, bv, dg, dgv, w, cnt};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got {req,vec,gnt,gvec,win,cnt}=%h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic gnt, input logic [7:0] gvec);
        bif.devreq  = req;
        bif.busgnt  = gnt;
        bif.busgvec = gvec;
    endtask

    logic [2:0] w1, w2;
    logic [7:0] v1, v2;

    initial begin
        RESET       = 1'b1;
        bif.devvec  = 32'h0044_4038;
        drive(4'b0000, 1'b0, 8'h00);

        //   name          rst req      gnt gvec   bq  bv     dg       dgv    w  cnt
        add("reset",        1, 4'b0000, 0, 8'h00, 0, 8'h00, 4'b0000, 8'h00, 0, 16'd0);
        add("idle",         0, 4'b0000, 0, 8'h00, 0, 8'h00, 4'b0000, 8'h00, 0, 16'd0);
        add("req0",         0, 4'b0001, 0, 8'h00, 1, 8'h38, 4'b0000, 8'h00, 0, 16'd0);
        add("req0_hold",    0, 4'b0001, 0, 8'h00, 1, 8'h38, 4'b0000, 8'h00, 0, 16'd0);
        add("gnt0",         0, 4'b0001, 1, 8'h38, 0, 8'h38, 4'b0001, 8'h38, 0, 16'd1);
        add("done0",        0, 4'b0000, 0, 8'h00, 0, 8'h38, 4'b0000, 8'h38, 0, 16'd1);
        add("idle0",        0, 4'b0000, 0, 8'h00, 0, 8'h38, 4'b0000, 8'h38, 0, 16'd1);
        add("mm_req",       0, 4'b0001, 0, 8'h00, 1, 8'h38, 4'b0000, 8'h38, 0, 16'd1);
        add("mm_badvec",    0, 4'b0001, 1, 8'h70, 1, 8'h38, 4'b0000, 8'h38, 0, 16'd1);
        add("mm_goodvec",   0, 4'b0001, 1, 8'h38, 0, 8'h38, 4'b0001, 8'h38, 0, 16'd2);
        add("mm_done",      0, 4'b0000, 0, 8'h00, 0, 8'h38, 4'b0000, 8'h38, 0, 16'd2);
        add("wd_req",       0, 4'b0001, 0, 8'h00, 1, 8'h38, 4'b0000, 8'h38, 0, 16'd2);
        add("wd_drop",      0, 4'b0010, 0, 8'h00, 0, 8'h38, 4'b0000, 8'h38, 0, 16'd2);
        add("wd_dev1",      0, 4'b0010, 0, 8'h00, 1, 8'h40, 4'b0000, 8'h38, 1, 16'd2);
        add("wd_gnt1",      0, 4'b0010, 1, 8'h40, 0, 8'h40, 4'b0010, 8'h40, 1, 16'd3);
        add("wd_done",      0, 4'b0000, 0, 8'h00, 0, 8'h40, 4'b0000, 8'h40, 1, 16'd3);
        add("race_req",     0, 4'b0001, 0, 8'h00, 1, 8'h38, 4'b0000, 8'h40, 0, 16'd3);
        add("race_gnt",     0, 4'b0000, 1, 8'h38, 0, 8'h38, 4'b0001, 8'h38, 0, 16'd4);
        add("race_done",    0, 4'b0000, 0, 8'h00, 0, 8'h38, 4'b0000, 8'h38, 0, 16'd4);
        add("rst_req",      0, 4'b0001, 0, 8'h00, 1, 8'h38, 4'b0000, 8'h38, 0, 16'd4);
        add("rst_inreq",    1, 4'b0001, 0, 8'h00, 0, 8'h00, 4'b0000, 8'h00, 0, 16'd0);
        add("rst_lategnt",  0, 4'b0000, 1, 8'h38, 0, 8'h00, 4'b0000, 8'h00, 0, 16'd0);

        foreach (tbl[i]) begin
            RESET = tbl[i].rst;
            drive(tbl[i].req, tbl[i].gnt, tbl[i].gvec);
            step();
            chk(tbl[i].name, tbl[i].bq, tbl[i].bv, tbl[i].dg, tbl[i].dgv, tbl[i].w, tbl[i].cnt);
        end

        // Priority between dev1 and dev2; a solo dev1 grant first leaves the RR pointer at 2.
`ifdef BRARB_RR_EN
        w1 = 3'd2; v1 = 8'h44; w2 = 3'd1; v2 = 8'h40;
`else
        w1 = 3'd1; v1 = 8'h40; w2 = 3'd2; v2 = 8'h44;
`endif
        drive(4'b0010, 1'b0, 8'h00); step();
        chk("pri_solo_req", 1, 8'h40, 4'b0000, 8'h00, 1, 16'd1 - 16'd1);
        drive(4'b0010, 1'b1, 8'h40); step();
        chk("pri_solo_gnt", 0, 8'h40, 4'b0010, 8'h40, 1, 16'd1);
        drive(4'b0000, 1'b0, 8'h00); step(); step();
        chk("pri_solo_idle", 0, 8'h40, 4'b0000, 8'h40, 1, 16'd1);
        drive(4'b0110, 1'b0, 8'h00); step();
        chk("pri_first_req", 1, v1, 4'b0000, 8'h40, w1, 16'd1);
        drive(4'b0110, 1'b1, v1); step();
        chk("pri_first_gnt", 0, v1, 4'b0001 << w1, v1, w1, 16'd2);
        drive(4'b0110 & ~(4'b0001 << w1), 1'b0, 8'h00); step();
        chk("pri_pulse_end", 0, v1, 4'b0000, v1, w1, 16'd2);
        step();
        chk("pri_second_req", 1, v2, 4'b0000, v1, w2, 16'd2);
        drive(4'b0110 & ~(4'b0001 << w1), 1'b1, v2); step();
        chk("pri_second_gnt", 0, v2, 4'b0001 << w2, v2, w2, 16'd3);
        drive(4'b0000, 1'b0, 8'h00); step();
        chk("pri_second_done", 0, v2, 4'b0000, v2, w2, 16'd3);

        // Preload the grant counter to 0xFFFF while idle, then deliver one grant to wrap it.
        force dut.grantcnt_q = 16'hFFFF;
        step();
        release dut.grantcnt_q;
        step();
        chk("wrap_preload", 0, v2, 4'b0000, v2, w2, 16'hFFFF);
        drive(4'b0001, 1'b0, 8'h00); step();
        chk("wrap_req", 1, 8'h38, 4'b0000, v2, 0, 16'hFFFF);
        drive(4'b0001, 1'b1, 8'h38); step();
        chk("wrap_gnt", 0, 8'h38, 4'b0001, 8'h38, 0, 16'h0000);
        drive(4'b0000, 1'b0, 8'h00); step();
        chk("wrap_done", 0, 8'h38, 4'b0000, 8'h38, 0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
